// File: rtl/pipeline_types.sv
// pipeline_types: inter-stage payloads and fetch-stage types.
package pipeline_types;

  import rv32_isa::RegWidth;
  import rv32_isa::InstrWidth;

  // IF -> ID register contents
  typedef struct packed {
    logic [RegWidth-1:0]   pc;
    logic [InstrWidth-1:0] instruction;
    logic                  valid;
  } if_id_t;

  // One returned instruction waiting for ID
  typedef struct packed {
    logic [RegWidth-1:0]   pc;
    logic [InstrWidth-1:0] instruction;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/rv32_isa.sv
// rv32_isa: RV32 architectural constants shared across the pipeline.
package rv32_isa;

  localparam int unsigned RegWidth   = 32;
  localparam int unsigned InstrWidth = 32;

  // addi x0, x0, 0
  localparam logic [InstrWidth-1:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small in-order instruction queue between the memory response
// and the ID register. Head is always slot 0; a pop shifts the queue down.
module fetch_buffer
  import pipeline_types::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iPush,
  input  fetch_entry_t    iPushData,
  input  logic            iPop,
  input  logic            iFlush,
  output fetch_entry_t    oHead,
  output logic [CntW-1:0] oCount
);

  localparam int unsigned     EntryW = $bits(fetch_entry_t);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);
  localparam logic [CntW-1:0] OneC   = CntW'(1);

  logic [Depth*EntryW-1:0] mem_q, mem_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [CntW-1:0]         base;

  assign oHead  = mem_q[EntryW-1:0];
  assign oCount = count_q;

  // Next queue contents: pop shifts first, then a push lands in the first free slot
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    base    = count_q;
    if (iFlush) begin
      count_d = '0;
    end else begin
      if (iPop && (count_q != '0)) begin
        for (int unsigned i = 0; i + 1 < Depth; i++) begin
          mem_d[i*EntryW +: EntryW] = mem_q[(i+1)*EntryW +: EntryW];
        end
        base = count_q - OneC;
      end
      count_d = base;
      if (iPush && (base < DepthC)) begin
        mem_d[32'(base)*EntryW +: EntryW] = iPushData;
        count_d = base + OneC;
      end
    end
  end

  // Queue storage and occupancy
  always_ff @(posedge iClk) begin
    if (iRst) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Issues word-aligned instruction reads, buffers
// in-order responses and feeds the registered IF/ID payload to ID.
// Define FETCH_PREFETCH_EN for two outstanding requests / two-entry buffer;
// otherwise one request at a time with a one-entry buffer.
module fetch_unit
  import rv32_isa::RegWidth;
  import pipeline_types::*;
#(
  parameter logic [RegWidth-1:0] ResetVector = 32'h0000_0000,
  parameter logic [31:0]         NopInstr    = rv32_isa::NopInstr
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStall,
  input  logic                iRedirect,
  input  logic [RegWidth-1:0] iRedirTarget,
  output logic                oImemReq,
  output logic [RegWidth-1:0] oImemAddr,
  input  logic                iImemGnt,
  input  logic                iImemRValid,
  input  logic [31:0]         iImemRData,
  output if_id_t              oID
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned MaxOutst = 2;
`else
  localparam int unsigned MaxOutst = 1;
`endif
  localparam int unsigned     CntW = $clog2(MaxOutst + 1);
  localparam logic [CntW-1:0] MaxC = CntW'(MaxOutst);
  localparam logic [CntW-1:0] OneC = CntW'(1);

  fetch_state_e        state_q, state_d;
  logic [RegWidth-1:0] pc_q, pc_d;
  logic [CntW-1:0]     outst_q, outst_d;
  logic [CntW-1:0]     drop_q, drop_d;
  if_id_t              oid_q, oid_d;

  logic [CntW-1:0]     outst_nxt;
  logic [CntW-1:0]     buf_count;
  fetch_entry_t        buf_head, rsp_entry;
  logic                buf_push, buf_pop, buf_flush, buf_empty;
  logic                imem_req, grant, rsp_fetch;
  logic [RegWidth-1:0] rsp_pc;
  if_id_t              bubble;
  logic                redir_target_unused;

  assign redir_target_unused = ^iRedirTarget[1:0];

  assign buf_empty = (buf_count == '0);
  assign imem_req  = (state_q == S_FETCH) && ((MaxC - buf_count) > outst_q);
  assign grant     = imem_req && iImemGnt;
  assign rsp_fetch = (state_q == S_FETCH) && iImemRValid;
  assign outst_nxt = outst_q + CntW'(grant) - CntW'(rsp_fetch);

  // In-flight requests are consecutive words ending just below the fetch PC,
  // so the oldest one's address is recovered instead of being queued.
  assign rsp_pc    = pc_q - (RegWidth'(outst_q) << 2);
  assign rsp_entry = '{pc: rsp_pc, instruction: iImemRData};
  assign bubble    = '{pc: oid_q.pc, instruction: NopInstr, valid: 1'b0};

  assign oImemReq  = imem_req;
  assign oImemAddr = pc_q;
  assign oID       = oid_q;

  fetch_buffer #(
    .Depth(MaxOutst)
  ) u_buf (
    .iClk     (iClk),
    .iRst     (iRst),
    .iPush    (buf_push),
    .iPushData(rsp_entry),
    .iPop     (buf_pop),
    .iFlush   (buf_flush),
    .oHead    (buf_head),
    .oCount   (buf_count)
  );

  // Next-state: FSM, fetch PC, request/drop accounting and IF/ID payload
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    oid_d     = oid_q;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    buf_flush = 1'b0;

    if (grant) pc_d = pc_q + 32'd4;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: outst_d = outst_nxt;
      S_DRAIN: begin
        if (iImemRValid && (drop_q != '0)) begin
          drop_d = drop_q - OneC;
          if (drop_q == OneC) state_d = S_FETCH;
        end
      end
      default: state_d = S_RESET;
    endcase

    if (iRedirect) begin
      // Redirect outranks stall; a response this cycle is discarded, and
      // everything still in flight (including this cycle's grant) is dropped.
      pc_d      = {iRedirTarget[RegWidth-1:2], 2'b00};
      buf_flush = 1'b1;
      oid_d     = bubble;
      if (state_q == S_FETCH) begin
        drop_d  = outst_nxt;
        outst_d = '0;
        state_d = (outst_nxt != '0) ? S_DRAIN : S_FETCH;
      end
    end else if (!iStall) begin
      if (!buf_empty) begin
        buf_pop  = 1'b1;
        buf_push = rsp_fetch;
        oid_d    = '{pc: buf_head.pc, instruction: buf_head.instruction, valid: 1'b1};
      end else if (rsp_fetch) begin
        // Empty buffer: response goes straight to ID
        oid_d = '{pc: rsp_pc, instruction: iImemRData, valid: 1'b1};
      end else begin
        oid_d = bubble;
      end
    end else begin
      buf_push = rsp_fetch;
    end
  end

  // Fetch state registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_RESET;
      pc_q    <= ResetVector;
      outst_q <= '0;
      drop_q  <= '0;
      oid_q   <= '{pc: ResetVector, instruction: NopInstr, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      oid_q   <= oid_d;
    end
  end

endmodule
